xbar_config_loader: RTL and testbench

//  Upstream config stage for the LUT-tile crossbar. Accepts the crossbar select

---
 rtl/xbar_config_loader.sv | 167 ++++++++++++++++
 tb/tb_xbar_config_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_config_loader.sv
// Crossbar config loader: streams select words into a shadow register,
// range-checks every field, then commits atomically to the crossbar.
//
// Ports:
//   clk            : clock, all state on rising edge
//   reset          : asynchronous, active-low reset
//   io_cfg_start   : 1-cycle pulse, opens a new load session (top priority)
//   io_cfg_valid   : io_cfg_data is valid
//   io_cfg_ready   : a word is accepted this cycle (combinational)
//   io_cfg_data    : config word, LSB-first ordering
//   io_cfg_busy    : session in progress (LOAD, CHECK or COMMIT)
//   io_cfg_done    : 1-cycle pulse, new config committed
//   io_cfg_err     : sticky, last session rejected
//   io_mux_configs : active select fields to the crossbar
module xbar_config_loader #(
    parameter int NUM_INS  = 27,
    parameter int NUM_OUTS = 36,
    parameter int SEL_W    = 5,
    parameter int WORD_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_cfg_start,
    input  logic                      io_cfg_valid,
    output logic                      io_cfg_ready,
    input  logic [WORD_W-1:0]         io_cfg_data,
    output logic                      io_cfg_busy,
    output logic                      io_cfg_done,
    output logic                      io_cfg_err,
    output logic [NUM_OUTS*SEL_W-1:0] io_mux_configs
);

    localparam int CFG_W     = NUM_OUTS * SEL_W;
    localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int WC_W      = $clog2(NUM_WORDS + 1);
    localparam int FI_W      = $clog2(NUM_OUTS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CFG_W-1:0]   r_shadow;
    logic [CFG_W-1:0]   r_cfg;
    logic [WC_W-1:0]    r_wcnt;
    logic [FI_W-1:0]    r_fidx;
    logic               r_err;
    logic               r_done;
    logic               r_busy;

    logic               w_accept;
    logic               w_last_word;
    logic               w_last_field;
    logic               w_bad;
    logic [SEL_W-1:0]   w_field;
    logic [CFG_W-1:0]   w_shadow_wr;

    assign io_cfg_ready   = (r_state == S_LOAD) && !io_cfg_start;
    assign io_cfg_busy    = r_busy;
    assign io_cfg_done    = r_done;
    assign io_cfg_err     = r_err;
    assign io_mux_configs = r_cfg;

    assign w_accept     = io_cfg_ready && io_cfg_valid;
    assign w_last_word  = int'(r_wcnt) == NUM_WORDS - 1;
    assign w_last_field = int'(r_fidx) == NUM_OUTS - 1;
    assign w_bad        = int'(w_field) >= NUM_INS;

    // Word k lands at bit k*WORD_W; bits past CFG_W in the
    // final word have no destination and simply fall away.
    always_comb begin
        w_shadow_wr = r_shadow;
        for (int b = 0; b < CFG_W; b++) begin
            if ((b / WORD_W) == int'(r_wcnt)) begin
                w_shadow_wr[b] = io_cfg_data[b % WORD_W];
            end
        end
    end

    always_comb begin
        w_field = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            if (int'(r_fidx) == i) begin
                w_field = r_shadow[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (io_cfg_start) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_IDLE;
                S_LOAD: begin
                    if (w_accept && w_last_word) begin
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_last_field) begin
                        w_state_nxt = S_COMMIT;
                    end
                end
                S_COMMIT: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_cfg    <= '0;
            r_wcnt   <= '0;
            r_fidx   <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_nxt != S_IDLE);
            if (io_cfg_start) begin
                r_wcnt <= '0;
                r_fidx <= '0;
                r_err  <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            r_shadow <= w_shadow_wr;
                            r_wcnt   <= r_wcnt + WC_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_fidx <= r_fidx + FI_W'(1);
                        end
                    end
                    S_COMMIT: begin
                        r_cfg  <= r_shadow;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xbar_config_loader.sv
// Testbench for xbar_config_loader: directed sessions checked against a
// timeline model of the loader, plus literal latency and field checks.
module tb_xbar_config_loader;

    localparam int CFG_W = 180;
    localparam int NW    = 12;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             valid = 1'b0;
    logic [15:0]      data  = '0;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [CFG_W-1:0] cfg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xbar_config_loader dut (
        .clk            (clk),
        .reset          (reset),
        .io_cfg_start   (start),
        .io_cfg_valid   (valid),
        .io_cfg_ready   (ready),
        .io_cfg_data    (data),
        .io_cfg_busy    (busy),
        .io_cfg_done    (done),
        .io_cfg_err     (err),
        .io_mux_configs (cfg)
    );

    task automatic chk(input string nm, input logic [CFG_W-1:0] act,
                       input logic [CFG_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk_img(input int off, input int bad_idx);
        logic [CFG_W-1:0] img;
        img = '0;
        for (int i = 0; i < 36; i++) begin
            img[i*5 +: 5] = 5'((i + off) % 27);
            if (i == bad_idx) img[i*5 +: 5] = 5'd27;
        end
        return img;
    endfunction

    function automatic int first_bad(input logic [CFG_W-1:0] img);
        for (int i = 0; i < 36; i++) begin
            if (int'(img[i*5 +: 5]) >= 27) return i;
        end
        return -1;
    endfunction

    // Timeline model: a session collects 12 words, then the outcome
    // (reject at first bad field, or commit) arrives a fixed number
    // of edges later.
    bit               m_loading = 0;
    int               m_k       = 0;
    logic [CFG_W-1:0] m_img     = '0;
    logic [CFG_W-1:0] m_cfg     = '0;
    int               m_timer   = 0;
    bit               m_bad     = 0;
    bit               m_done    = 0;
    bit               m_err     = 0;

    task automatic model_step();
        int f;
        if (!reset) begin
            m_loading = 0; m_k = 0; m_img = '0; m_cfg = '0;
            m_timer = 0; m_bad = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (start) begin
                m_loading = 1; m_k = 0; m_err = 0; m_timer = 0;
            end else if (m_loading) begin
                if (valid) begin
                    for (int b = 0; b < 16; b++) begin
                        if (m_k*16 + b < CFG_W) m_img[m_k*16 + b] = data[b];
                    end
                    m_k++;
                    if (m_k == NW) begin
                        m_loading = 0;
                        f = first_bad(m_img);
                        m_bad = (f >= 0);
                        m_timer = m_bad ? f + 1 : 37;
                    end
                end
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    if (m_bad) m_err = 1;
                    else begin
                        m_cfg = m_img;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) model_step();

    always @(negedge clk) begin
        chk("ready", CFG_W'(ready), CFG_W'(m_loading && !start));
        chk("busy",  CFG_W'(busy),  CFG_W'(m_loading || m_timer > 0));
        chk("done",  CFG_W'(done),  CFG_W'(m_done));
        chk("err",   CFG_W'(err),   CFG_W'(m_err));
        chk("cfg",   cfg,           m_cfg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_img(input logic [CFG_W-1:0] img, input int n,
                            input bit gaps, output int t_last);
        logic [191:0] wide;
        bit acc;
        int tries;
        wide = {12'hFFF, img};
        t_last = cyc;
        for (int k = 0; k < n; k++) begin
            acc = 0;
            tries = 0;
            while (!acc && tries < 50) begin
                valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                data = valid ? wide[k*16 +: 16] : 16'($urandom);
                @(negedge clk);
                acc = valid && ready;
                tick();
                tries++;
            end
            if (!acc) begin
                n_tests++; n_fail++;
                $display("FAIL word_accept_timeout: word %0d never accepted", k);
            end
        end
        valid = 1'b0;
        t_last = cyc;
    endtask

    task automatic wait_done(input int t0, output int dt);
        int lim;
        lim = 0;
        dt = -1;
        while (lim < 200) begin
            @(negedge clk);
            if (done) begin
                dt = cyc - t0;
                break;
            end
            lim++;
        end
    endtask

    task automatic wait_err(input int t0, output int dt);
        int lim;
        lim = 0;
        dt = -1;
        while (lim < 200) begin
            @(negedge clk);
            if (err) begin
                dt = cyc - t0;
                break;
            end
            lim++;
        end
    endtask

    logic [CFG_W-1:0] img2;
    int t0;
    int dt;

    initial begin
        img2 = mk_img(0, -1);

        // 1: reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); valid = 1'($urandom); data = 16'($urandom);
            tick();
        end
        chk("rst_cfg", cfg, '0);
        start = 0; valid = 0; data = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", CFG_W'(ready), '0);
        chk("rel_busy",  CFG_W'(busy),  '0);
        tick();

        // 2: good load, no stalls
        pulse_start();
        send_img(img2, NW, 0, t0);
        wait_done(t0, dt);
        chk("t2_latency", CFG_W'(dt), CFG_W'(37));
        chk("t2_cfg", cfg, img2);
        chk("t2_f35", CFG_W'(cfg[179:175]), CFG_W'(8));
        chk("t2_f20", CFG_W'(cfg[104:100]), CFG_W'(20));
        chk("t2_err", CFG_W'(err), '0);
        tick();
        chk("t2_done_clr", CFG_W'(done), '0);

        // 3: field 20 out of range
        pulse_start();
        send_img(mk_img(0, 20), NW, 0, t0);
        wait_err(t0, dt);
        chk("t3_err_edge", CFG_W'(dt), CFG_W'(21));
        chk("t3_busy", CFG_W'(busy), '0);
        chk("t3_cfg_kept", cfg, img2);
        repeat (20) tick();
        chk("t3_err_sticky", CFG_W'(err), CFG_W'(1));

        // 4: valid while idle, then random valid gaps
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; data = 16'($urandom);
            tick();
        end
        valid = 1'b0;
        pulse_start();
        chk("t4_err_clr", CFG_W'(err), '0);
        send_img(img2, NW, 1, t0);
        wait_done(t0, dt);
        chk("t4_latency", CFG_W'(dt), CFG_W'(37));
        chk("t4_cfg", cfg, img2);
        tick();

        // 5: restart mid-session with same-cycle valid
        pulse_start();
        send_img(mk_img(5, -1), 5, 0, t0);
        start = 1'b1; valid = 1'b1; data = 16'hBEEF;
        @(negedge clk);
        chk("t5_ready_start", CFG_W'(ready), '0);
        tick();
        start = 1'b0; valid = 1'b0;
        send_img(mk_img(3, -1), NW, 0, t0);
        wait_done(t0, dt);
        chk("t5_latency", CFG_W'(dt), CFG_W'(37));
        chk("t5_cfg", cfg, mk_img(3, -1));
        tick();

        // 6: async reset mid-CHECK after a commit
        pulse_start();
        send_img(mk_img(9, -1), NW, 0, t0);
        repeat (10) tick();
        chk("t6_busy_pre", CFG_W'(busy), CFG_W'(1));
        #2 reset = 1'b0;
        #1;
        chk("t6_cfg_zero", cfg, '0);
        chk("t6_busy", CFG_W'(busy), '0);
        chk("t6_err", CFG_W'(err), '0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        send_img(img2, NW, 0, t0);
        wait_done(t0, dt);
        chk("t6_latency", CFG_W'(dt), CFG_W'(37));
        chk("t6_cfg", cfg, img2);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
